jtcps1_sdram_arb: RTL and testbench

JTCPS1_SDRAM_ARB -- requirements
Module: jtcps1_sdram_arb

---
 rtl/jtcps1_sdram_arb_if.sv | 28 ++
 rtl/jtcps1_sdram_arb.sv | 166 ++++++++++++++++
 tb/tb_jtcps1_sdram_arb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtcps1_sdram_arb_if.sv
// Bus bundle between the eight CPS1 video clients, the SDRAM arbiter and the SDRAM controller.
// The arbiter uses the slave view; the clients/controller side uses the master view.
interface jtcps1_sdram_arb_if #(
  parameter int AW = 22
);
  logic [7:0]      slot_cs;
  logic [8*AW-1:0] slot_addr;
  logic [15:0]     slot_din;
  logic [7:0]      slot_ok;
  logic [8*32-1:0] slot_dout;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_wr;
  logic [15:0]     sdram_din;
  logic            sdram_ack;
  logic            sdram_rdy;
  logic [31:0]     sdram_dout;

  modport slave (
    input  slot_cs, slot_addr, slot_din, sdram_ack, sdram_rdy, sdram_dout,
    output slot_ok, slot_dout, sdram_req, sdram_addr, sdram_wr, sdram_din
  );

  modport master (
    output slot_cs, slot_addr, slot_din, sdram_ack, sdram_rdy, sdram_dout,
    input  slot_ok, slot_dout, sdram_req, sdram_addr, sdram_wr, sdram_din
  );
endinterface

// File: rtl/jtcps1_sdram_arb.sv
// Eight-slot SDRAM arbiter: slot 0 has fixed priority, slots 1-7 share a round-robin,
// one outstanding transaction at a time, one access per assertion of a slot's cs.
module jtcps1_sdram_arb #(
  parameter int AW     = 22,
  parameter int WRSLOT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  jtcps1_sdram_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      rr_q, rr_d;
  logic [7:0]      armed_q, armed_d;
  logic [7:0]      ok_q, ok_d;
  logic [255:0]    dout_q, dout_d;
  logic            req_q, req_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     din_q, din_d;

  logic [7:0]      eligible;
  logic [2:0]      pick;
  logic            pick_vld;
  logic [2:0]      rr_idx;
  logic            done;

  // Grant selection: slot 0 first, otherwise scan 1..7 starting just after the last RR grant
  always_comb begin
    eligible = bus.slot_cs & ~ok_q & armed_q;
    pick     = 3'd0;
    pick_vld = 1'b0;
    rr_idx   = 3'd1;
    if (eligible[0]) begin
      pick     = 3'd0;
      pick_vld = 1'b1;
    end else begin
      for (int i = 1; i <= 7; i++) begin
        rr_idx = 3'(((int'(rr_q) + i - 1) % 7) + 1);
        if (!pick_vld && eligible[rr_idx]) begin
          pick     = rr_idx;
          pick_vld = 1'b1;
        end else begin
          pick     = pick;
        end
      end
    end
  end

  // Next-state logic for the transaction FSM and all registered outputs
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    dout_d  = dout_q;
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    done    = 1'b0;
    // A completed slot stays done until its cs is seen low, then it re-arms
    ok_d    = ok_q & bus.slot_cs;
    armed_d = armed_q | (ok_q & ~bus.slot_cs);

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = REQ;
          req_d   = 1'b1;
          grant_d = pick;
          addr_d  = bus.slot_addr[int'(pick)*AW +: AW];
          wr_d    = (pick == 3'(WRSLOT));
          din_d   = bus.slot_din;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.sdram_ack) begin
          req_d = 1'b0;
          if (bus.sdram_rdy) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (bus.sdram_rdy) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    // If the client withdrew its cs mid-transaction the result is dropped and it stays armed
    if (done && bus.slot_cs[grant_q]) begin
      ok_d[grant_q]    = 1'b1;
      armed_d[grant_q] = 1'b0;
      if (!wr_q) begin
        dout_d[int'(grant_q)*32 +: 32] = bus.sdram_dout;
      end else begin
        dout_d[int'(grant_q)*32 +: 32] = dout_q[int'(grant_q)*32 +: 32];
      end
    end else begin
      ok_d[grant_q] = ok_d[grant_q];
    end

    if (done && (grant_q != 3'd0)) begin
      rr_d = grant_q;
    end else begin
      rr_d = rr_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 3'd0;
      rr_q    <= 3'd7;
      armed_q <= 8'hFF;
      ok_q    <= 8'h00;
      dout_q  <= 256'd0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      armed_q <= armed_d;
      ok_q    <= ok_d;
      dout_q  <= dout_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign bus.slot_ok    = ok_q;
  assign bus.slot_dout  = dout_q;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;
  assign bus.sdram_wr   = wr_q;
  assign bus.sdram_din  = din_q;

endmodule

// File: tb/tb_jtcps1_sdram_arb.sv
// Directed bench for jtcps1_sdram_arb: the bench plays both the slot clients and the SDRAM controller.
module tb_jtcps1_sdram_arb;
  localparam int AW = 22;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  jtcps1_sdram_arb_if #(.AW(AW)) bus ();

  jtcps1_sdram_arb #(.AW(AW), .WRSLOT(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.slot_cs    = 8'h00;
    bus.slot_addr  = '0;
    bus.slot_din   = 16'h0000;
    bus.sdram_ack  = 1'b0;
    bus.sdram_rdy  = 1'b0;
    bus.sdram_dout = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_addr(input int n, input logic [AW-1:0] a);
    bus.slot_addr[n*AW +: AW] = a;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.sdram_req === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic serve(input logic [31:0] d, input int ack_dly, input int rdy_dly);
    repeat (ack_dly) tick();
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    repeat (rdy_dly) tick();
    bus.sdram_rdy  = 1'b1;
    bus.sdram_dout = d;
    tick();
    bus.sdram_rdy  = 1'b0;
    bus.sdram_dout = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (bus.sdram_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.sdram_req); else pass_cnt++;
    total_cnt++; if (bus.sdram_wr !== 1'b0) $display("FAIL rst_wr: got %b want 0", bus.sdram_wr); else pass_cnt++;
    total_cnt++; if (bus.sdram_addr !== 22'd0) $display("FAIL rst_addr: got %h want 0", bus.sdram_addr); else pass_cnt++;
    total_cnt++; if (bus.sdram_din !== 16'd0) $display("FAIL rst_din: got %h want 0", bus.sdram_din); else pass_cnt++;
    total_cnt++; if (bus.slot_ok !== 8'h00) $display("FAIL rst_ok: got %h want 00", bus.slot_ok); else pass_cnt++;
    total_cnt++; if (bus.slot_dout !== 256'd0) $display("FAIL rst_dout: got %h want 0", bus.slot_dout); else pass_cnt++;
  endtask

  task automatic test_single_read();
    do_reset();
    set_addr(1, 22'h12345);
    bus.slot_cs[1] = 1'b1;
    tick();
    total_cnt++; if (bus.sdram_req !== 1'b1) $display("FAIL rd_req_latency: got %b want 1", bus.sdram_req); else pass_cnt++;
    total_cnt++; if (bus.sdram_wr !== 1'b0) $display("FAIL rd_wr: got %b want 0", bus.sdram_wr); else pass_cnt++;
    total_cnt++; if (bus.sdram_addr !== 22'h12345) $display("FAIL rd_addr: got %h want 12345", bus.sdram_addr); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h12345)
      $display("FAIL rd_hold: got req=%b addr=%h want req=1 addr=12345", bus.sdram_req, bus.sdram_addr); else pass_cnt++;
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    total_cnt++; if (bus.sdram_req !== 1'b0) $display("FAIL rd_req_drop: got %b want 0", bus.sdram_req); else pass_cnt++;
    total_cnt++; if (bus.slot_ok[1] !== 1'b0) $display("FAIL rd_ok_early: got %b want 0", bus.slot_ok[1]); else pass_cnt++;
    repeat (4) tick();
    bus.sdram_rdy  = 1'b1;
    bus.sdram_dout = 32'hCAFEBABE;
    tick();
    bus.sdram_rdy  = 1'b0;
    bus.sdram_dout = 32'h0;
    total_cnt++; if (bus.slot_ok !== 8'h02) $display("FAIL rd_ok: got %h want 02", bus.slot_ok); else pass_cnt++;
    total_cnt++; if (bus.slot_dout[32 +: 32] !== 32'hCAFEBABE) $display("FAIL rd_dout: got %h want cafebabe", bus.slot_dout[32 +: 32]); else pass_cnt++;
    repeat (5) tick();
    total_cnt++; if (bus.slot_ok[1] !== 1'b1 || bus.slot_dout[32 +: 32] !== 32'hCAFEBABE)
      $display("FAIL rd_held: got ok=%b dout=%h want ok=1 dout=cafebabe", bus.slot_ok[1], bus.slot_dout[32 +: 32]); else pass_cnt++;
    total_cnt++; if (bus.sdram_req !== 1'b0) $display("FAIL rd_no_regrant: got %b want 0", bus.sdram_req); else pass_cnt++;
    bus.slot_cs[1] = 1'b0;
    tick();
    total_cnt++; if (bus.slot_ok[1] !== 1'b0) $display("FAIL rd_ok_clear: got %b want 0", bus.slot_ok[1]); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int exp_order[8] = '{1, 2, 3, 4, 5, 6, 1, 2};
    bit got;
    int n;
    logic [AW-1:0] a;
    do_reset();
    for (int s = 1; s <= 6; s++) begin
      a = 22'(s * 32'h1000 + s);
      set_addr(s, a);
    end
    bus.slot_cs = 8'b0111_1110;
    for (int k = 0; k < 8; k++) begin
      n = exp_order[k];
      a = 22'(n * 32'h1000 + n);
      wait_req(got);
      total_cnt++; if (!got) $display("FAIL rr_req_timeout_%0d: got no req want req", k); else pass_cnt++;
      total_cnt++; if (bus.sdram_addr !== a) $display("FAIL rr_grant_%0d: got addr %h want %h (slot %0d)", k, bus.sdram_addr, a, n); else pass_cnt++;
      serve(32'h1000_0000 | 32'(n + 16 * k), 1, 1);
      total_cnt++; if (bus.slot_ok[n] !== 1'b1 || bus.slot_dout[n*32 +: 32] !== (32'h1000_0000 | 32'(n + 16 * k)))
        $display("FAIL rr_done_%0d: got ok=%b dout=%h want ok=1 dout=%h", k, bus.slot_ok[n], bus.slot_dout[n*32 +: 32], 32'h1000_0000 | 32'(n + 16 * k));
      else pass_cnt++;
      bus.slot_cs[n] = 1'b0;
      tick();
      bus.slot_cs[n] = 1'b1;
    end
  endtask

  task automatic test_priority();
    bit got;
    do_reset();
    set_addr(0, 22'h00A00);
    set_addr(1, 22'h00A01);
    set_addr(3, 22'h00A03);
    set_addr(4, 22'h00A04);
    bus.slot_cs[3] = 1'b1;
    wait_req(got);
    total_cnt++; if (!got || bus.sdram_addr !== 22'h00A03) $display("FAIL pri_first: got req=%b addr=%h want req=1 addr=00a03", got, bus.sdram_addr); else pass_cnt++;
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    bus.slot_cs[0] = 1'b1;
    bus.slot_cs[1] = 1'b1;
    bus.slot_cs[4] = 1'b1;
    tick();
    bus.sdram_rdy  = 1'b1;
    bus.sdram_dout = 32'h3333_3333;
    tick();
    bus.sdram_rdy  = 1'b0;
    total_cnt++; if (bus.slot_ok[3] !== 1'b1) $display("FAIL pri_slot3_ok: got %b want 1", bus.slot_ok[3]); else pass_cnt++;
    bus.slot_cs[3] = 1'b0;
    wait_req(got);
    total_cnt++; if (!got || bus.sdram_addr !== 22'h00A00) $display("FAIL pri_slot0: got req=%b addr=%h want req=1 addr=00a00", got, bus.sdram_addr); else pass_cnt++;
    serve(32'h0000_F00D, 0, 0);
    total_cnt++; if (bus.slot_ok[0] !== 1'b1 || bus.slot_dout[31:0] !== 32'h0000_F00D)
      $display("FAIL pri_slot0_done: got ok=%b dout=%h want ok=1 dout=0000f00d", bus.slot_ok[0], bus.slot_dout[31:0]); else pass_cnt++;
    bus.slot_cs[0] = 1'b0;
    wait_req(got);
    total_cnt++; if (!got || bus.sdram_addr !== 22'h00A04) $display("FAIL pri_rr_resume: got req=%b addr=%h want req=1 addr=00a04", got, bus.sdram_addr); else pass_cnt++;
  endtask

  task automatic test_write();
    bit got;
    do_reset();
    set_addr(7, 22'h3FFFF);
    bus.slot_din   = 16'hA5A5;
    bus.slot_cs[7] = 1'b1;
    tick();
    got = (bus.sdram_req === 1'b1);
    total_cnt++; if (!got) $display("FAIL wr_req: got %b want 1", bus.sdram_req); else pass_cnt++;
    total_cnt++; if (bus.sdram_wr !== 1'b1) $display("FAIL wr_flag: got %b want 1", bus.sdram_wr); else pass_cnt++;
    total_cnt++; if (bus.sdram_din !== 16'hA5A5) $display("FAIL wr_din: got %h want a5a5", bus.sdram_din); else pass_cnt++;
    total_cnt++; if (bus.sdram_addr !== 22'h3FFFF) $display("FAIL wr_addr: got %h want 3ffff", bus.sdram_addr); else pass_cnt++;
    serve(32'hDEADBEEF, 1, 2);
    total_cnt++; if (bus.slot_ok[7] !== 1'b1) $display("FAIL wr_ok: got %b want 1", bus.slot_ok[7]); else pass_cnt++;
    total_cnt++; if (bus.slot_dout[224 +: 32] !== 32'h0) $display("FAIL wr_dout_unchanged: got %h want 0", bus.slot_dout[224 +: 32]); else pass_cnt++;
  endtask

  task automatic test_held_cs();
    bit got;
    int extra;
    do_reset();
    set_addr(2, 22'h02222);
    bus.slot_cs[2] = 1'b1;
    wait_req(got);
    total_cnt++; if (!got) $display("FAIL held_first_req: got no req want req"); else pass_cnt++;
    serve(32'h2222_2222, 0, 1);
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.sdram_req === 1'b1) extra++;
    end
    total_cnt++; if (extra !== 0) $display("FAIL held_extra_req: got %0d req cycles want 0", extra); else pass_cnt++;
    total_cnt++; if (bus.slot_ok[2] !== 1'b1 || bus.slot_dout[64 +: 32] !== 32'h2222_2222)
      $display("FAIL held_ok: got ok=%b dout=%h want ok=1 dout=22222222", bus.slot_ok[2], bus.slot_dout[64 +: 32]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    bit got;
    do_reset();
    set_addr(6, 22'h06666);
    set_addr(5, 22'h00155);
    bus.slot_cs[6] = 1'b1;
    wait_req(got);
    serve(32'h6666_6666, 0, 0);
    total_cnt++; if (bus.slot_ok[6] !== 1'b1) $display("FAIL rmw_pre_ok6: got %b want 1", bus.slot_ok[6]); else pass_cnt++;
    bus.slot_cs[5] = 1'b1;
    wait_req(got);
    total_cnt++; if (!got || bus.sdram_addr !== 22'h00155) $display("FAIL rmw_req5: got req=%b addr=%h want req=1 addr=00155", got, bus.sdram_addr); else pass_cnt++;
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    rst_n       = 1'b0;
    bus.slot_cs = 8'h00;
    tick();
    rst_n = 1'b1;
    total_cnt++; if (bus.sdram_req !== 1'b0 || bus.sdram_wr !== 1'b0 || bus.sdram_addr !== 22'd0 || bus.sdram_din !== 16'd0)
      $display("FAIL rmw_sdram_rst: got req=%b wr=%b addr=%h din=%h want all 0", bus.sdram_req, bus.sdram_wr, bus.sdram_addr, bus.sdram_din); else pass_cnt++;
    total_cnt++; if (bus.slot_ok !== 8'h00) $display("FAIL rmw_ok_rst: got %h want 00", bus.slot_ok); else pass_cnt++;
    total_cnt++; if (bus.slot_dout !== 256'd0) $display("FAIL rmw_dout_rst: got %h want 0", bus.slot_dout); else pass_cnt++;
    bus.sdram_rdy  = 1'b1;
    bus.sdram_dout = 32'h5555_5555;
    tick();
    bus.sdram_rdy  = 1'b0;
    tick();
    total_cnt++; if (bus.slot_ok !== 8'h00 || bus.slot_dout !== 256'd0)
      $display("FAIL rmw_stray_rdy: got ok=%h dout5=%h want ok=00 dout5=0", bus.slot_ok, bus.slot_dout[160 +: 32]); else pass_cnt++;
    total_cnt++; if (bus.sdram_req !== 1'b0) $display("FAIL rmw_idle: got req=%b want 0", bus.sdram_req); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_priority();
    test_write();
    test_held_cs();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
